// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - raster timing constants and RAM buffer offsets for video_timing
package video_timing_pkg;

  typedef logic [9:0]  hcount_t;
  typedef logic [8:0]  vcount_t;
  typedef logic [20:0] word_addr_t;

  localparam int H_TOTAL        = 704;
  localparam int H_ACTIVE       = 512;
  localparam int V_TOTAL        = 370;
  localparam int V_ACTIVE       = 342;
  localparam int SND_FETCH_H    = 600;
  localparam int WORDS_PER_LINE = 32;

  // Distance below RAM_TOP of each buffer, in bytes
  localparam logic [21:0] SCREEN_MAIN_OFS = 22'h005900;
  localparam logic [21:0] SCREEN_ALT_OFS  = 22'h00D900;
  localparam logic [21:0] SOUND_MAIN_OFS  = 22'h000300;
  localparam logic [21:0] SOUND_ALT_OFS   = 22'h005F00;

  function automatic word_addr_t word_base(input logic [21:0] ram_top, input logic [21:0] ofs);
    logic [21:0] byte_addr;
    byte_addr = ram_top - ofs;
    return byte_addr[21:1];
  endfunction

endpackage

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster counters, blanking, and screen/sound fetch address generation
// All outputs are registered decodes of the counter position one clk earlier.
module video_timing
  import video_timing_pkg::*;
#(
  parameter logic [21:0] RAM_TOP = 22'h400000
) (
  input  logic        clk,
  input  logic        _systemReset,
  input  logic        vid_alt,
  input  logic        snd_alt,
  output logic        _hblank,
  output logic        _vblank,
  output logic        loadPixels,
  output logic        loadSound,
  output logic [20:0] videoAddr,
  output logic [20:0] soundAddr,
  output logic        frameStart
);

  localparam word_addr_t SCREEN_MAIN = word_base(RAM_TOP, SCREEN_MAIN_OFS);
  localparam word_addr_t SCREEN_ALT  = word_base(RAM_TOP, SCREEN_ALT_OFS);
  localparam word_addr_t SOUND_MAIN  = word_base(RAM_TOP, SOUND_MAIN_OFS);
  localparam word_addr_t SOUND_ALT   = word_base(RAM_TOP, SOUND_ALT_OFS);

  localparam hcount_t H_LAST  = hcount_t'(H_TOTAL - 1);
  localparam hcount_t H_ACT   = hcount_t'(H_ACTIVE);
  localparam hcount_t H_SND   = hcount_t'(SND_FETCH_H);
  localparam vcount_t V_LAST  = vcount_t'(V_TOTAL - 1);
  localparam vcount_t V_ACT   = vcount_t'(V_ACTIVE);
  localparam int      FETCH_SHIFT = $clog2(H_ACTIVE / WORDS_PER_LINE);

  hcount_t hcount;
  vcount_t vcount;
  logic    h_active;
  logic    v_active;
  logic    pix_due;
  logic    frame_end;

  assign h_active  = (hcount < H_ACT);
  assign v_active  = (vcount < V_ACT);
  assign pix_due   = h_active && v_active && (hcount[FETCH_SHIFT-1:0] == '0);
  assign frame_end = (hcount == H_LAST) && (vcount == V_LAST);

  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      _hblank    <= 1'b1;
      _vblank    <= 1'b1;
      loadPixels <= 1'b0;
      loadSound  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      _hblank    <= h_active;
      _vblank    <= v_active;
      loadPixels <= pix_due;
      loadSound  <= (hcount == H_SND);
      frameStart <= (hcount == '0) && (vcount == '0);
    end
  end

  // Each address steps just after its strobe; buffer selects are taken only at frame end
  always_ff @(posedge clk or negedge _systemReset) begin
    if (!_systemReset) begin
      videoAddr <= SCREEN_MAIN;
      soundAddr <= SOUND_MAIN;
    end else begin
      if (frame_end) begin
        videoAddr <= vid_alt ? SCREEN_MAIN : SCREEN_ALT;
      end else if (loadPixels) begin
        videoAddr <= videoAddr + 1'b1;
      end
      if (frame_end) begin
        soundAddr <= snd_alt ? SOUND_ALT : SOUND_MAIN;
      end else if (loadSound) begin
        soundAddr <= soundAddr + 1'b1;
      end
    end
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter RAM_TOP, default 22'h400000, byte address one past the top of RAM; all buffer bases are derived from it.
REQ-002 clk  input  1  16 MHz pixel clock; every counter advances on each rising edge, with no enable.
REQ-003 _systemReset  input  1  asynchronous, active-low reset.
REQ-004 vid_alt  input  1  1 = main screen buffer, 0 = alternate screen buffer.
REQ-005 snd_alt  input  1  1 = alternate sound buffer, 0 = main sound buffer.
REQ-006 _hblank  output  1  low during horizontal blanking.
REQ-007 _vblank  output  1  low during vertical blanking.
REQ-008 loadPixels  output  1  one-clk strobe; a screen word is due at videoAddr.
REQ-009 loadSound  output  1  one-clk strobe; a sound/PWM word is due at soundAddr.
REQ-010 videoAddr  output  21  word address (byte address bits 21:1) of the next screen word.
REQ-011 soundAddr  output  21  word address of the current line's sound word.
REQ-012 frameStart  output  1  one-clk strobe at hcount=0, vcount=0.

Function
REQ-013 hcount SHALL count 0..703 and wrap to 0; vcount SHALL increment when hcount wraps, count 0..369, and wrap to 0.
REQ-014 _hblank SHALL be registered: 0 when hcount is 512..703, else 1.
REQ-015 _vblank SHALL be registered: 0 when vcount is 342..369, else 1.
REQ-016 Active lines are vcount<342; on these, loadPixels SHALL pulse when hcount<512 and hcount[3:0]==0, giving 32 pulses per line and 10944 per frame.
REQ-017 loadPixels SHALL never pulse when vcount>=342 or hcount>=512.
REQ-018 videoAddr SHALL be valid in the same cycle as loadPixels and SHALL increment by 1 on the following clk.
REQ-019 Word k of line v SHALL be at screenBase + 32*v + k; the last word of a frame is screenBase + 10943.
REQ-020 Screen bases: main = (RAM_TOP-0x5900)>>1, alternate = (RAM_TOP-0xD900)>>1.
REQ-021 Sound bases: main = (RAM_TOP-0x300)>>1, alternate = (RAM_TOP-0x5F00)>>1.
REQ-022 loadSound SHALL pulse once per line on all 370 lines, at hcount==600.
REQ-023 soundAddr SHALL equal soundBase + vcount during each loadSound pulse.
REQ-024 vid_alt and snd_alt SHALL be sampled only at hcount==703, vcount==369, and SHALL take effect from the next frame.
  - videoAddr reloads to the selected screenBase at that same point.
  - soundAddr reloads to the selected soundBase at that same point.
  - A toggle of either input mid-frame SHALL NOT affect the current frame.
REQ-025 Address arithmetic is 21-bit unsigned; no wrap occurs within a frame for any RAM_TOP >= 22'h020000.
REQ-026 Every output SHALL be registered, with no combinational path from input to output.

Reset
REQ-027 While _systemReset is low, the block SHALL hold:
  - hcount=0, vcount=0;
  - _hblank=1, _vblank=1;
  - loadPixels=0, loadSound=0, frameStart=0;
  - videoAddr = main screenBase, soundAddr = main soundBase.
REQ-028 On the first clk after release, frameStart SHALL pulse, and loadPixels SHALL pulse with videoAddr = main screenBase.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no further strobes.

Structure
REQ-030 A shared package SHALL hold the timing constants: H_TOTAL=704, H_ACTIVE=512, V_TOTAL=370, V_ACTIVE=342, SND_FETCH_H=600, WORDS_PER_LINE=32.
REQ-031 The package SHALL also hold the buffer offsets 0x5900, 0xD900, 0x300 and 0x5F00.
REQ-032 The block is a single module with no sub-modules; the h/v counters and the address generators are internal processes.

Verification
REQ-033 Free run with RAM_TOP=22'h400000 and vid_alt=1 SHALL give:
  - frame period 260480 clks;
  - _hblank low for 192 of every 704 clks;
  - _vblank low for 28*704 clks per frame.
REQ-034 Address check, first frame after reset:
  - first loadPixels at videoAddr 0x1FD380;
  - first pulse of line 1 at 0x1FD3A0;
  - last pulse of the frame at 0x1FFE3F;
  - exactly 10944 loadPixels pulses.
REQ-035 With snd_alt=0, loadSound SHALL give 370 pulses per frame, with soundAddr running from 0x1FFE80 to 0x1FFFF1 and each pulse at hcount 600.
REQ-036 Toggling vid_alt to 0 at vcount=100 SHALL leave the current frame at main; the next frame's first pulse SHALL be at 0x1F9380. Setting snd_alt=1 SHALL likewise make the next frame's first soundAddr 0x1FD080.
REQ-037 Asserting _systemReset at vcount=200, hcount=300 SHALL clear all outputs to their reset values asynchronously; after release, timing SHALL restart at frameStart with videoAddr 0x1FD380.
REQ-038 RAM_TOP=22'h100000 SHALL give a first videoAddr of 0x07D380 and a main soundAddr of 0x07FE80.
